uart_word_rx: RTL

Serial receive front end for the MIPS_UART datapath. Deserializes 8N1 UART frames from the `rx` pin and packs consecutive bytes, little-endian, into a `LENGTH`-bit word. On completion it presents the word on `Q` with a one-cycle `word_valid` strobe. `Q` feeds a data input of the 4-to-1 operand/write-back mux, and `word_valid` goes to the FSM that drives that mux's `sel`.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_byte.sv | 102 ++++++++++
 rtl/uart_word_rx.sv | 81 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
// States, default baud divisor for 50 MHz / 115200, and frame data width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, start/data/stop FSM, mid-bit sampling.
// byte_valid is a combinational strobe on the accepting stop sample; no backpressure.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_frame_err;

  logic [CW-1:0] w_limit;
  logic          w_tick;

  // The start check waits half a bit so every later sample lands mid-bit.
  assign w_limit = (r_state == START) ? HALF_M1 : FULL_M1;
  assign w_tick  = (r_cnt == w_limit);

  assign byte_data  = r_shift;
  assign byte_valid = (r_state == STOP) && w_tick && r_sync2 && !clear;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_frame_err <= 1'b0;
      if (clear) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_bit_idx <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            if (!r_sync2 && enable) r_state <= START;
          end
          START: begin
            if (w_tick) begin
              r_cnt     <= '0;
              r_bit_idx <= '0;
              r_state   <= r_sync2 ? IDLE : DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DATA: begin
            if (w_tick) begin
              r_cnt     <= '0;
              r_shift   <= {r_sync2, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) r_state <= STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STOP: begin
            // Return to IDLE at the stop sample so a back-to-back start edge is caught.
            if (w_tick) begin
              r_cnt       <= '0;
              r_state     <= IDLE;
              r_frame_err <= !r_sync2;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// Packs received UART bytes little-endian into a LENGTH-bit word; Q/word_valid
// update the cycle after the final stop sample. No handshake: capture Q on word_valid.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int LENGTH       = 32,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              rx,
  output logic [LENGTH-1:0] Q,
  output logic              word_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int LANES = LENGTH / UART_DATA_BITS;
  localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BW-1:0] LAST_LANE = BW'(LANES - 1);

  logic [7:0]        w_byte_data;
  logic              w_byte_valid;
  logic              w_frame_err;
  logic [LENGTH-1:0] w_word;

  logic [LENGTH-1:0] r_partial;
  logic [BW-1:0]     r_byte_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (clear),
    .rx        (rx),
    .byte_data (w_byte_data),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err),
    .busy      (busy)
  );

  assign frame_err = w_frame_err;

  // Partial word with the incoming byte merged into its lane.
  always_comb begin
    w_word = r_partial;
    for (int k = 0; k < LANES; k++) begin
      if (r_byte_cnt == BW'(k)) w_word[8*k +: 8] = w_byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_partial  <= '0;
      r_byte_cnt <= '0;
      Q          <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear || w_frame_err) begin
        r_partial  <= '0;
        r_byte_cnt <= '0;
      end else if (w_byte_valid) begin
        if (r_byte_cnt == LAST_LANE) begin
          Q          <= w_word;
          word_valid <= 1'b1;
          r_partial  <= '0;
          r_byte_cnt <= '0;
        end else begin
          r_partial  <= w_word;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule
